// File: rtl/mem_fill_check_pkg.sv
// Shared types and constants for the memory fill/check master.
package mem_fill_check_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic MODE_INC  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Right-shifting Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam logic [31:0] LFSR_ZERO_SEED = 32'h0000_0001;

endpackage

// File: rtl/mem_fill_check_master_pattern.sv
// Pattern generator: incrementing or Galois LFSR word sequence, reloadable from a seed.
module fill_pattern_gen
    import mem_fill_check_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              load,
    input  logic              advance,
    input  logic              mode,
    input  logic [DATA_W-1:0] seed,
    output logic [DATA_W-1:0] word
);

    logic mode_q;

    function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] s);
        return (s >> 1) ^ (s[0] ? DATA_W'(LFSR_TAPS) : '0);
    endfunction

    // An all-zero LFSR would lock up, so a zero seed is substituted.
    always_ff @(posedge clk) begin
        if (load) begin
            mode_q <= mode;
            if (mode == MODE_LFSR && seed == '0) begin
                word <= DATA_W'(LFSR_ZERO_SEED);
            end else begin
                word <= seed;
            end
        end else if (advance) begin
            if (mode_q == MODE_LFSR) begin
                word <= lfsr_step(word);
            end else begin
                word <= word + DATA_W'(1);
            end
        end
    end

endmodule

// File: rtl/mem_fill_check_master.sv
// Avalon-MM BIST master: fills a RAM region with a pattern, reads it back and compares.
// Optional FILL_CHECK_ERRCNT_EN adds a saturating mismatch count and first-mismatch address.
module mem_fill_check_master
    import mem_fill_check_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   cfg_base,
    input  logic [ADDR_W:0]     cfg_len,
    input  logic                cfg_mode,
    input  logic [DATA_W-1:0]   cfg_seed,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_chipselect,
    output logic                avm_write,
    output logic                avm_read,
    output logic [DATA_W/8-1:0] avm_byteenable,
    output logic [DATA_W-1:0]   avm_writedata,
    output logic                avm_clken,
    input  logic [DATA_W-1:0]   avm_readdata,
    input  logic                avm_waitrequest
`ifdef FILL_CHECK_ERRCNT_EN
    ,
    output logic [ADDR_W:0]     err_count,
    output logic [ADDR_W-1:0]   err_first_addr
`endif
);

    localparam int BE_W = DATA_W / 8;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W:0]     idx;
    logic [ADDR_W-1:0]   base_q;
    logic                mode_q;
    logic [DATA_W-1:0]   seed_q;
    logic                start_acc;
    logic                accept;
    logic                last;
    logic                fill_last;
    logic                read_acc;
    logic                gen_load;
    logic                gen_mode;
    logic [DATA_W-1:0]   gen_seed;
    logic [DATA_W-1:0]   pat_word;
    logic [ADDR_W-1:0]   cur_addr;
    logic                mismatch;
    logic [RD_LAT-1:0]   vld_p;
    logic [DATA_W-1:0]   exp_p [RD_LAT];
`ifdef FILL_CHECK_ERRCNT_EN
    logic [ADDR_W-1:0]   addr_p [RD_LAT];

    function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] v);
        return (&v) ? v : v + (ADDR_W+1)'(1);
    endfunction
`endif

    assign start_acc = start && (state == IDLE || state == DONE);
    assign accept    = (avm_read || avm_write) && !avm_waitrequest;
    assign last      = (idx + (ADDR_W+1)'(1)) == len_q;
    assign fill_last = (state == FILL) && accept && last;
    assign read_acc  = (state == READ) && accept;
    assign cur_addr  = base_q + idx[ADDR_W-1:0];
    assign mismatch  = vld_p[RD_LAT-1] && (avm_readdata != exp_p[RD_LAT-1]);

    // The generator is reseeded at start and again between fill and readback.
    assign gen_load = start_acc || fill_last;
    assign gen_seed = start_acc ? cfg_seed : seed_q;
    assign gen_mode = start_acc ? cfg_mode : mode_q;

    fill_pattern_gen #(
        .DATA_W (DATA_W)
    ) u_pattern (
        .clk     (clk),
        .load    (gen_load),
        .advance (accept),
        .mode    (gen_mode),
        .seed    (gen_seed),
        .word    (pat_word)
    );

    always_comb begin
        state_nxt      = state;
        busy           = 1'b0;
        done           = 1'b0;
        avm_write      = 1'b0;
        avm_read       = 1'b0;
        avm_chipselect = 1'b0;
        avm_byteenable = '0;
        avm_address    = '0;
        avm_writedata  = '0;
        avm_clken      = 1'b1;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) begin
                    state_nxt = (cfg_len == '0) ? DONE : FILL;
                end
            end
            FILL: begin
                busy           = 1'b1;
                avm_write      = 1'b1;
                avm_chipselect = 1'b1;
                avm_byteenable = {BE_W{1'b1}};
                avm_address    = cur_addr;
                avm_writedata  = pat_word;
                if (accept && last) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                busy           = 1'b1;
                avm_read       = 1'b1;
                avm_chipselect = 1'b1;
                avm_byteenable = {BE_W{1'b1}};
                avm_address    = cur_addr;
                if (accept && last) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (vld_p == '0) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Control: state, word index, compare-pipe valids and sticky status
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            vld_p <= '0;
            err   <= 1'b0;
        end else begin
            state    <= state_nxt;
            vld_p[0] <= read_acc;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_p[k] <= vld_p[k-1];
            end
            if (start_acc) begin
                idx <= '0;
                err <= 1'b0;
            end else begin
                if (accept) begin
                    idx <= fill_last ? '0 : idx + (ADDR_W+1)'(1);
                end
                if (mismatch) begin
                    err <= 1'b1;
                end
            end
        end
    end

    // Datapath: latched configuration and expected-word pipe aligned to read latency
    always_ff @(posedge clk) begin
        if (start_acc) begin
            len_q  <= cfg_len;
            base_q <= cfg_base;
            mode_q <= cfg_mode;
            seed_q <= cfg_seed;
        end
        exp_p[0] <= pat_word;
        for (int k = 1; k < RD_LAT; k++) begin
            exp_p[k] <= exp_p[k-1];
        end
    end

`ifdef FILL_CHECK_ERRCNT_EN
    always_ff @(posedge clk) begin
        addr_p[0] <= cur_addr;
        for (int k = 1; k < RD_LAT; k++) begin
            addr_p[k] <= addr_p[k-1];
        end
    end

    // Sticky err still low means this mismatch is the first of the run.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_count      <= '0;
            err_first_addr <= '0;
        end else if (start_acc) begin
            err_count      <= '0;
            err_first_addr <= '0;
        end else if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (!err) begin
                err_first_addr <= addr_p[RD_LAT-1];
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_fill_check_master.sv
// Scoreboard bench for mem_fill_check_master with a single-port RAM slave model.
module tb_mem_fill_check_master;

    typedef struct {
        bit          wr;
        logic [10:0] addr;
        logic [31:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [10:0] cfg_base = '0;
    logic [11:0] cfg_len = '0;
    logic        cfg_mode = 1'b0;
    logic [31:0] cfg_seed = '0;
    logic        busy, done, err;
    logic [10:0] avm_address;
    logic        avm_chipselect, avm_write, avm_read, avm_clken;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
`ifdef FILL_CHECK_ERRCNT_EN
    logic [11:0] err_count;
    logic [10:0] err_first_addr;
`endif

    logic [31:0] mem [2048];
    txn_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    bit          rand_wait = 1'b0;
    bit          corrupt = 1'b0;
    bit          held_vld = 1'b0;
    bit          held_wr;
    logic [10:0] held_addr;
    logic [31:0] held_data;
    logic [31:0] lfsr_tab [4] = '{32'h0000_0001, 32'h8020_0003, 32'hC030_0002, 32'h6018_0001};

    mem_fill_check_master dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_base        (cfg_base),
        .cfg_len         (cfg_len),
        .cfg_mode        (cfg_mode),
        .cfg_seed        (cfg_seed),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .avm_address     (avm_address),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_read        (avm_read),
        .avm_byteenable  (avm_byteenable),
        .avm_writedata   (avm_writedata),
        .avm_clken       (avm_clken),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
`ifdef FILL_CHECK_ERRCNT_EN
        ,
        .err_count       (err_count),
        .err_first_addr  (err_first_addr)
`endif
    );

    always #5 clk = ~clk;

    // RAM slave with read latency 1; optionally corrupts the word stored at address 5
    always @(posedge clk) begin
        if (avm_chipselect && avm_write && !avm_waitrequest)
            mem[avm_address] <= (corrupt && avm_address == 11'd5) ? (avm_writedata ^ 32'h1) : avm_writedata;
        if (avm_chipselect && avm_read && !avm_waitrequest)
            avm_readdata <= mem[avm_address];
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            avm_waitrequest = rand_wait ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted transfer, checks stall stability
    always @(negedge clk) begin
        txn_t t;
        if (reset) begin
            held_vld = 1'b0;
        end else begin
            if (held_vld) begin
                chk("stall_req", {62'd0, avm_write, avm_read}, {62'd0, held_wr, !held_wr});
                chk("stall_addr", 64'(avm_address), 64'(held_addr));
                if (held_wr) chk("stall_data", 64'(avm_writedata), 64'(held_data));
            end
            if ((avm_read || avm_write) && !avm_waitrequest) begin
                if (avm_write) wr_cnt++;
                if (avm_read) rd_cnt++;
                if (q.size() == 0) begin
                    chk("unexpected_txn", 64'(avm_address), 64'h1_0000_0000);
                end else begin
                    t = q.pop_front();
                    chk("txn_kind", 64'(avm_write), 64'(t.wr));
                    chk("txn_addr", 64'(avm_address), 64'(t.addr));
                    if (t.wr) chk("txn_data", 64'(avm_writedata), 64'(t.data));
                    chk("txn_be", 64'(avm_byteenable), 64'hF);
                end
            end
            held_vld  = (avm_read || avm_write) && avm_waitrequest;
            held_wr   = avm_write;
            held_addr = avm_address;
            held_data = avm_writedata;
        end
    end

    function automatic logic [31:0] pat(input logic mode, input logic [31:0] seed, input int i);
        if (!mode) return seed + 32'(i);
        return lfsr_tab[i];
    endfunction

    task automatic run_case(input logic [10:0] base, input logic [11:0] len, input logic mode,
                            input logic [31:0] seed, input bit exp_err, input bit poke, output int lat);
        txn_t t;
        bit   poked = 1'b0;
        for (int i = 0; i < int'(len); i++) begin
            t.wr = 1'b1; t.addr = base + 11'(i); t.data = pat(mode, seed, i);
            q.push_back(t);
        end
        for (int i = 0; i < int'(len); i++) begin
            t.wr = 1'b0; t.addr = base + 11'(i); t.data = '0;
            q.push_back(t);
        end
        wr_cnt = 0;
        rd_cnt = 0;
        cfg_base = base; cfg_len = len; cfg_mode = mode; cfg_seed = seed;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        lat = 0;
        while (!done && lat < 5000) begin
            @(negedge clk);
            lat++;
            if (poke && !poked && avm_read) begin
                start = 1'b1; cfg_base = 11'h123; cfg_len = 12'd1; poked = 1'b1;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        chk("run_timeout", 64'(lat < 5000), 64'd1);
        chk("done", 64'(done), 64'd1);
        chk("busy_end", 64'(busy), 64'd0);
        chk("err", 64'(err), 64'(exp_err));
        chk("queue_empty", 64'(q.size()), 64'd0);
        chk("write_count", 64'(wr_cnt), 64'(len));
        chk("read_count", 64'(rd_cnt), 64'(len));
        if (poke) chk("poke_seen", 64'(poked), 64'd1);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_req", {61'd0, avm_read, avm_write, avm_chipselect}, 64'd0);
        chk("rst_addr", 64'(avm_address), 64'd0);
        chk("rst_wdata", 64'(avm_writedata), 64'd0);
        chk("rst_clken", 64'(avm_clken), 64'd1);
        reset = 1'b0;
        @(negedge clk);

        run_case(11'd0, 12'd4, 1'b0, 32'd100, 1'b0, 1'b0, lat);
        chk("latency_len4", 64'(lat), 64'd10);
        chk("mem_word3", 64'(mem[3]), 64'd103);

        run_case(11'd2046, 12'd4, 1'b0, 32'd7, 1'b0, 1'b0, lat);
        chk("wrap_mem0", 64'(mem[0]), 64'd9);

        run_case(11'd10, 12'd4, 1'b1, 32'd0, 1'b0, 1'b0, lat);
        chk("lfsr_mem13", 64'(mem[13]), 64'h6018_0001);

        rand_wait = 1'b1;
        run_case(11'd100, 12'd10, 1'b0, 32'hA5A5_0000, 1'b0, 1'b0, lat);
        rand_wait = 1'b0;

        corrupt = 1'b1;
        run_case(11'd0, 12'd8, 1'b0, 32'h0000_1000, 1'b1, 1'b0, lat);
        corrupt = 1'b0;
`ifdef FILL_CHECK_ERRCNT_EN
        chk("err_count", 64'(err_count), 64'd1);
        chk("err_first_addr", 64'(err_first_addr), 64'd5);
`endif

        run_case(11'd50, 12'd0, 1'b0, 32'd1, 1'b0, 1'b0, lat);
        chk("latency_len0", 64'(lat), 64'd0);

        run_case(11'd20, 12'd6, 1'b0, 32'd300, 1'b0, 1'b1, lat);

        // Abort a long fill with reset after a few writes
        begin
            txn_t t;
            for (int i = 0; i < 16; i++) begin
                t.wr = 1'b1; t.addr = 11'(i); t.data = 32'(i);
                q.push_back(t);
            end
        end
        cfg_base = 11'd0; cfg_len = 12'd16; cfg_mode = 1'b0; cfg_seed = 32'd0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (3) @(negedge clk);
        chk("midfill_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_req", {61'd0, avm_read, avm_write, avm_chipselect}, 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_err", 64'(err), 64'd0);
        reset = 1'b0;
        q.delete();
        repeat (3) @(negedge clk);
        chk("idle_after_abort", {61'd0, avm_read, avm_write, busy}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
